// File: rtl/mem_port_arbiter.sv
// Two-cycle arbiter sharing one single-port memory between instruction fetch and load/store.
// Load/store wins by default; a starvation counter forces a fetch grant after STARVE_LIMIT wins.
module mem_port_arbiter #(
    parameter int unsigned WORD_SIZE    = 32,
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned STARVE_LIMIT = 3,
    parameter int unsigned TEXT_LIMIT   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 if_req,
    input  logic [ADDR_W-1:0]    if_addr,
    output logic                 if_ack,
    output logic [WORD_SIZE-1:0] if_rdata,
    output logic                 if_rvalid,
    input  logic                 dm_req,
    input  logic                 dm_we,
    input  logic [ADDR_W-1:0]    dm_addr,
    input  logic [WORD_SIZE-1:0] dm_wdata,
    output logic                 dm_ack,
    output logic [WORD_SIZE-1:0] dm_rdata,
    output logic                 dm_rvalid,
    output logic                 dm_err,
    output logic                 mem_write,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata
);

    localparam int unsigned CntW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);
    localparam logic [ADDR_W:0] TextLim = (ADDR_W + 1)'(TEXT_LIMIT);

    typedef enum logic [1:0] {StIdle, StServeIf, StServeDm} state_e;

    state_e          state_q;
    logic [CntW-1:0] starve_q;
    logic            dm_we_q;
    logic            dm_blocked_q;

    logic dm_wins;
    logic if_wins;
    logic dm_store_ok;

    assign dm_wins     = dm_req && (!if_req || (starve_q < StarveMax));
    assign if_wins     = if_req && !dm_wins;
    assign dm_store_ok = ({1'b0, dm_addr} >= TextLim);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            starve_q     <= '0;
            dm_we_q      <= 1'b0;
            dm_blocked_q <= 1'b0;
            if_ack       <= 1'b0;
            if_rdata     <= '0;
            if_rvalid    <= 1'b0;
            dm_ack       <= 1'b0;
            dm_rdata     <= '0;
            dm_rvalid    <= 1'b0;
            dm_err       <= 1'b0;
            mem_write    <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
        end else begin
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;
            dm_err    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (dm_wins) begin
                        state_q      <= StServeDm;
                        dm_ack       <= 1'b1;
                        mem_addr     <= dm_addr;
                        mem_wdata    <= dm_wdata;
                        mem_write    <= dm_we && dm_store_ok;
                        dm_we_q      <= dm_we;
                        dm_blocked_q <= dm_we && !dm_store_ok;
                        // Count only wins that actually made a fetch wait.
                        if (!if_req) begin
                            starve_q <= '0;
                        end else if (starve_q != StarveMax) begin
                            starve_q <= starve_q + CntW'(1);
                        end
                    end else if (if_wins) begin
                        state_q   <= StServeIf;
                        if_ack    <= 1'b1;
                        mem_addr  <= if_addr;
                        mem_write <= 1'b0;
                        starve_q  <= '0;
                    end else begin
                        starve_q <= '0;
                    end
                end
                StServeIf: begin
                    if_ack    <= 1'b0;
                    if_rdata  <= mem_rdata;
                    if_rvalid <= 1'b1;
                    state_q   <= StIdle;
                end
                StServeDm: begin
                    dm_ack    <= 1'b0;
                    mem_write <= 1'b0;
                    if (!dm_we_q) begin
                        dm_rdata  <= mem_rdata;
                        dm_rvalid <= 1'b1;
                    end
                    dm_err  <= dm_blocked_q;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (no text protection, and protection below 16)
// share one stimulus stream and are checked against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int STARVE = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, dm_req, dm_we;
    logic [7:0]  if_addr, dm_addr;
    logic [31:0] dm_wdata;

    logic        if_ack_w [2];
    logic        if_rvalid_w [2];
    logic        dm_ack_w [2];
    logic        dm_rvalid_w [2];
    logic        dm_err_w [2];
    logic        mem_write_w [2];
    logic [31:0] if_rdata_w [2];
    logic [31:0] dm_rdata_w [2];
    logic [31:0] mem_wdata_w [2];
    logic [31:0] mem_rdata_w [2];
    logic [7:0]  mem_addr_w [2];

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        if (i == 2) return 32'h8C0F000F;
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [31:0] mem [256];
        logic        inited = 1'b0;

        always @(posedge clk) begin
            if (!inited) begin
                for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
                inited <= 1'b1;
            end else if (mem_write_w[g]) begin
                mem[mem_addr_w[g]] <= mem_wdata_w[g];
            end
        end

        assign mem_rdata_w[g] = mem[mem_addr_w[g]];

        mem_port_arbiter #(
            .WORD_SIZE   (32),
            .ADDR_W      (8),
            .STARVE_LIMIT(STARVE),
            .TEXT_LIMIT  (g * 16)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .if_req   (if_req),
            .if_addr  (if_addr),
            .if_ack   (if_ack_w[g]),
            .if_rdata (if_rdata_w[g]),
            .if_rvalid(if_rvalid_w[g]),
            .dm_req   (dm_req),
            .dm_we    (dm_we),
            .dm_addr  (dm_addr),
            .dm_wdata (dm_wdata),
            .dm_ack   (dm_ack_w[g]),
            .dm_rdata (dm_rdata_w[g]),
            .dm_rvalid(dm_rvalid_w[g]),
            .dm_err   (dm_err_w[g]),
            .mem_write(mem_write_w[g]),
            .mem_addr (mem_addr_w[g]),
            .mem_wdata(mem_wdata_w[g]),
            .mem_rdata(mem_rdata_w[g])
        );
    end

    int checks = 0;
    int errors = 0;

    // Reference model: one outstanding access at a time, tracked as a transaction.
    bit          m_busy, m_dm, m_we;
    int          m_starve;
    logic [7:0]  m_addr;
    logic [31:0] m_wdata;
    logic [31:0] ref_mem [2][256];
    logic [31:0] e_if_rdata [2];
    logic [31:0] e_dm_rdata [2];
    bit          e_if_ack, e_dm_ack, e_if_rv, e_dm_rv;
    bit          e_err [2];
    bit          e_mw [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        m_busy = 0; m_dm = 0; m_we = 0; m_starve = 0;
        m_addr = '0; m_wdata = '0;
        e_if_ack = 0; e_dm_ack = 0; e_if_rv = 0; e_dm_rv = 0;
        for (int k = 0; k < 2; k++) begin
            e_if_rdata[k] = '0; e_dm_rdata[k] = '0; e_err[k] = 0; e_mw[k] = 0;
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("if_ack[%0d]", k), 32'(if_ack_w[k]), 32'(e_if_ack));
            chk($sformatf("dm_ack[%0d]", k), 32'(dm_ack_w[k]), 32'(e_dm_ack));
            chk($sformatf("if_rvalid[%0d]", k), 32'(if_rvalid_w[k]), 32'(e_if_rv));
            chk($sformatf("dm_rvalid[%0d]", k), 32'(dm_rvalid_w[k]), 32'(e_dm_rv));
            chk($sformatf("dm_err[%0d]", k), 32'(dm_err_w[k]), 32'(e_err[k]));
            chk($sformatf("mem_write[%0d]", k), 32'(mem_write_w[k]), 32'(e_mw[k]));
            chk($sformatf("mem_addr[%0d]", k), 32'(mem_addr_w[k]), 32'(m_addr));
            chk($sformatf("mem_wdata[%0d]", k), mem_wdata_w[k], m_wdata);
            chk($sformatf("if_rdata[%0d]", k), if_rdata_w[k], e_if_rdata[k]);
            chk($sformatf("dm_rdata[%0d]", k), dm_rdata_w[k], e_dm_rdata[k]);
        end
    endtask

    // Predict the effect of the coming edge from the current inputs, advance, then compare.
    task automatic step();
        bit g_dm, g_if;
        e_if_ack = 0; e_dm_ack = 0; e_if_rv = 0; e_dm_rv = 0;
        for (int k = 0; k < 2; k++) begin
            e_err[k] = 0; e_mw[k] = 0;
        end
        if (!m_busy) begin
            g_dm = dm_req && (!if_req || m_starve < STARVE);
            g_if = !g_dm && if_req;
            if (g_dm) begin
                m_addr = dm_addr; m_wdata = dm_wdata; m_we = dm_we; e_dm_ack = 1;
                for (int k = 0; k < 2; k++) e_mw[k] = dm_we && (int'(dm_addr) >= 16 * k);
            end else if (g_if) begin
                m_addr = if_addr; e_if_ack = 1;
            end
            if (g_dm && if_req) m_starve = (m_starve < STARVE) ? m_starve + 1 : STARVE;
            else m_starve = 0;
            m_busy = g_dm || g_if;
            m_dm = g_dm;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (!m_dm) begin
                    e_if_rv = 1; e_if_rdata[k] = ref_mem[k][m_addr];
                end else if (!m_we) begin
                    e_dm_rv = 1; e_dm_rdata[k] = ref_mem[k][m_addr];
                end else if (int'(m_addr) >= 16 * k) begin
                    ref_mem[k][m_addr] = m_wdata;
                end else begin
                    e_err[k] = 1;
                end
            end
            m_busy = 0;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive_random();
        if (e_if_ack) begin
            if_req = ($urandom_range(0, 3) != 0); if_addr = 8'($urandom_range(0, 31));
        end else if (!if_req && $urandom_range(0, 2) == 0) begin
            if_req = 1'b1; if_addr = 8'($urandom_range(0, 31));
        end
        if (e_dm_ack) begin
            dm_req = ($urandom_range(0, 3) != 0); dm_addr = 8'($urandom_range(0, 31));
            dm_we = 1'($urandom_range(0, 1)); dm_wdata = $urandom;
        end else if (!dm_req && $urandom_range(0, 2) == 0) begin
            dm_req = 1'b1; dm_addr = 8'($urandom_range(0, 31));
            dm_we = 1'($urandom_range(0, 1)); dm_wdata = $urandom;
        end
    endtask

    initial begin
        int seq[$];
        int exp_seq[8] = '{1, 1, 1, 0, 1, 1, 1, 0};

        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 256; i++) ref_mem[k][i] = init_word(i);
        if_req = 0; dm_req = 0; dm_we = 0; if_addr = '0; dm_addr = '0; dm_wdata = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        reset_model();
        repeat (2) @(posedge clk);
        #1 check_all();
        @(negedge clk) rst_n = 1'b1;

        // Fetch of word 2.
        if_req = 1; if_addr = 8'h02;
        step();
        chk("tp1_ack", 32'(if_ack_w[0]), 32'd1);
        if_req = 0;
        step();
        chk("tp1_rvalid", 32'(if_rvalid_w[0]), 32'd1);
        chk("tp1_rdata", if_rdata_w[0], 32'h8C0F000F);
        step();

        // Store then load of 0x0F.
        dm_req = 1; dm_we = 1; dm_addr = 8'h0F; dm_wdata = 32'h12345678;
        step();
        chk("tp2_mem_write", 32'(mem_write_w[0]), 32'd1);
        chk("tp2_mem_addr", 32'(mem_addr_w[0]), 32'h0F);
        dm_we = 0;
        step();
        chk("tp2_store_no_rvalid", 32'(dm_rvalid_w[0]), 32'd0);
        step();
        dm_req = 0;
        step();
        chk("tp2_load_rvalid", 32'(dm_rvalid_w[0]), 32'd1);
        chk("tp2_load_rdata", dm_rdata_w[0], 32'h12345678);
        step();

        // Both requesters held high: grant pattern under the starvation limit.
        if_req = 1; if_addr = 8'h04; dm_req = 1; dm_we = 0; dm_addr = 8'h08;
        for (int n = 0; n < 40 && seq.size() < 8; n++) begin
            step();
            if (if_ack_w[0]) seq.push_back(0);
            else if (dm_ack_w[0]) seq.push_back(1);
        end
        chk("starve_grants", 32'(seq.size()), 32'd8);
        for (int i = 0; i < seq.size() && i < 8; i++)
            chk($sformatf("starve_grant%0d", i), 32'(seq[i]), 32'(exp_seq[i]));
        if_req = 0; dm_req = 0;
        step();
        step();

        // Text protection on the second instance.
        dm_req = 1; dm_we = 1; dm_addr = 8'h05; dm_wdata = 32'hDEADBEEF;
        step();
        chk("tl_blocked_mw", 32'(mem_write_w[1]), 32'd0);
        chk("tl_open_mw", 32'(mem_write_w[0]), 32'd1);
        dm_req = 0;
        step();
        chk("tl_err_pulse", 32'(dm_err_w[1]), 32'd1);
        chk("tl_no_err_open", 32'(dm_err_w[0]), 32'd0);
        step();
        chk("tl_err_one_cycle", 32'(dm_err_w[1]), 32'd0);
        chk("tl_mem5_kept", g_dut[1].mem[5], init_word(5));
        dm_req = 1; dm_we = 1; dm_addr = 8'h10; dm_wdata = 32'hCAFEF00D;
        step();
        chk("tl_ok_mw", 32'(mem_write_w[1]), 32'd1);
        dm_req = 0;
        step();
        chk("tl_ok_no_err", 32'(dm_err_w[1]), 32'd0);
        chk("tl_mem16", g_dut[1].mem[16], 32'hCAFEF00D);
        step();

        // Reset in the middle of a store's SERVE cycle.
        dm_req = 1; dm_we = 1; dm_addr = 8'h20; dm_wdata = 32'h0BADC0DE;
        step();
        dm_req = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mw0", 32'(mem_write_w[0]), 32'd0);
        chk("rst_mw1", 32'(mem_write_w[1]), 32'd0);
        chk("rst_ack", 32'(dm_ack_w[0]), 32'd0);
        reset_model();
        @(negedge clk) rst_n = 1'b1;
        repeat (3) step();
        chk("rst_mem32_kept", g_dut[0].mem[32], init_word(32));

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            step();
            drive_random();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
